// File: rtl/l298n_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l298n_pwm_pkg
// Description : Shared definitions for the multi-channel L298N PWM driver:
//               per-channel register offsets, CTRL bit positions and the
//               channel state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package l298n_pwm_pkg;

    // Register map: each channel owns a block of four consecutive words.
    localparam int c_regs_per_ch = 4;
    localparam int c_ofs_ctrl    = 0;
    localparam int c_ofs_period  = 1;
    localparam int c_ofs_duty    = 2;
    localparam int c_ofs_dead    = 3;

    // CTRL register fields
    localparam int c_ctrl_w         = 3;
    localparam int c_ctrl_en_bit    = 0;
    localparam int c_ctrl_dir_bit   = 1;
    localparam int c_ctrl_brake_bit = 2;

    // Per-channel bridge state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_BRAKE = 2'd3
    } ch_state_e;

endpackage
`default_nettype wire

// File: rtl/l298n_pwm_channel.sv
`default_nettype none
// ============================================================================
// Module      : l298n_pwm_channel
// Description : One H-bridge channel: CTRL/PERIOD/DUTY/DEAD registers,
//               PERIOD/DUTY shadow-to-active transfer, PWM counter,
//               dead-time counter and IDLE/RUN/DEAD/BRAKE state machine.
//               Bridge pins are registered from the current state/counter.
// Ports       : clk, rst_n (async, active-low)
//               i_wr_*        register write strobes (already decoded)
//               i_wdata_*     write data slices
//               o_ctrl/o_period/o_duty/o_dead  register readback
//               o_dead_st     channel is in DEAD
//               o_in1/o_in2/o_en  L298N IN1/IN2/EN pins
// Revision    : 1.0 - initial release
// ============================================================================
module l298n_pwm_channel
    import l298n_pwm_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DEAD_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wr_ctrl,
    input  logic                i_wr_period,
    input  logic                i_wr_duty,
    input  logic                i_wr_dead,
    input  logic [c_ctrl_w-1:0] i_wdata_ctrl,
    input  logic [CNT_W-1:0]    i_wdata_cnt,
    input  logic [DEAD_W-1:0]   i_wdata_dead,
    output logic [c_ctrl_w-1:0] o_ctrl,
    output logic [CNT_W-1:0]    o_period,
    output logic [CNT_W-1:0]    o_duty,
    output logic [DEAD_W-1:0]   o_dead,
    output logic                o_dead_st,
    output logic                o_in1,
    output logic                o_in2,
    output logic                o_en
);

    ch_state_e            r_state;
    ch_state_e            w_state_nxt;

    logic [c_ctrl_w-1:0]  r_ctrl;
    logic [CNT_W-1:0]     r_period_sh;
    logic [CNT_W-1:0]     r_duty_sh;
    logic [CNT_W-1:0]     r_period_act;
    logic [CNT_W-1:0]     r_duty_act;
    logic [DEAD_W-1:0]    r_dead;
    logic [CNT_W-1:0]     r_cnt;
    logic [DEAD_W-1:0]    r_dcnt;
    logic                 r_dir;
    logic                 r_in1;
    logic                 r_in2;
    logic                 r_en;

    logic [CNT_W-1:0]     w_period_sh_nxt;
    logic [CNT_W-1:0]     w_duty_sh_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [DEAD_W-1:0]    w_dcnt_nxt;
    logic                 w_dir_nxt;
    logic                 w_load_act;
    logic                 w_wrap;
    logic                 w_enable;
    logic                 w_dir;
    logic                 w_brake;
    logic                 w_in1_nxt;
    logic                 w_in2_nxt;
    logic                 w_en_nxt;

    assign w_enable = r_ctrl[c_ctrl_en_bit];
    assign w_dir    = r_ctrl[c_ctrl_dir_bit];
    assign w_brake  = r_ctrl[c_ctrl_brake_bit];

    // A write landing in the same cycle as a transfer is taken directly,
    // so the newest value is never lost behind a stale shadow.
    assign w_period_sh_nxt = i_wr_period ? i_wdata_cnt : r_period_sh;
    assign w_duty_sh_nxt   = i_wr_duty   ? i_wdata_cnt : r_duty_sh;

    // With a zero period the counter is pinned at 0 and every cycle counts
    // as a wrap, otherwise a channel set to PERIOD=0 could never pick up a
    // new period while running.
    assign w_wrap = (r_period_act == '0) || (r_cnt >= (r_period_act - CNT_W'(1)));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter and shadow-transfer decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_dcnt_nxt  = '0;
        w_dir_nxt   = r_dir;
        w_load_act  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_load_act = 1'b1;
                if (w_enable && !w_brake) begin
                    w_state_nxt = ST_RUN;
                    w_dir_nxt   = w_dir;
                end else if (w_enable && w_brake) begin
                    w_state_nxt = ST_BRAKE;
                end
            end
            ST_RUN: begin
                if (!w_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_brake || (w_dir != r_dir)) begin
                    w_state_nxt = ST_DEAD;
                end else begin
                    w_cnt_nxt  = w_wrap ? '0 : (r_cnt + CNT_W'(1));
                    w_load_act = w_wrap;
                end
            end
            ST_DEAD: begin
                // Dead time lasts DEAD+1 cycles; CTRL is only consulted at
                // the exit so late CTRL writes never restart the count.
                if (r_dcnt >= r_dead) begin
                    if (!w_enable) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_brake) begin
                        w_state_nxt = ST_BRAKE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        w_dir_nxt   = w_dir;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + DEAD_W'(1);
                end
            end
            ST_BRAKE: begin
                if (!w_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (!w_brake) begin
                    w_state_nxt = ST_DEAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pin values derived from the current state; registered below
    // ------------------------------------------------------------------
    always_comb begin
        w_en_nxt  = 1'b0;
        w_in1_nxt = r_in1;
        w_in2_nxt = r_in2;
        unique case (r_state)
            ST_IDLE: begin
                w_in1_nxt = 1'b0;
                w_in2_nxt = 1'b0;
            end
            ST_RUN: begin
                w_en_nxt  = (r_period_act != '0) && (r_cnt < r_duty_act);
                w_in1_nxt = r_dir;
                w_in2_nxt = ~r_dir;
            end
            ST_DEAD: begin
                w_en_nxt = 1'b0;
            end
            ST_BRAKE: begin
                w_en_nxt  = 1'b1;
                w_in1_nxt = 1'b0;
                w_in2_nxt = 1'b0;
            end
            default: begin
                w_in1_nxt = 1'b0;
                w_in2_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers, counters and output pins
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl       <= '0;
            r_period_sh  <= '0;
            r_duty_sh    <= '0;
            r_period_act <= '0;
            r_duty_act   <= '0;
            r_dead       <= '0;
            r_cnt        <= '0;
            r_dcnt       <= '0;
            r_dir        <= 1'b0;
            r_in1        <= 1'b0;
            r_in2        <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            if (i_wr_ctrl) begin
                r_ctrl <= i_wdata_ctrl;
            end
            if (i_wr_dead) begin
                r_dead <= i_wdata_dead;
            end
            r_period_sh <= w_period_sh_nxt;
            r_duty_sh   <= w_duty_sh_nxt;
            if (w_load_act) begin
                r_period_act <= w_period_sh_nxt;
                r_duty_act   <= w_duty_sh_nxt;
            end
            r_cnt  <= w_cnt_nxt;
            r_dcnt <= w_dcnt_nxt;
            r_dir  <= w_dir_nxt;
            r_in1  <= w_in1_nxt;
            r_in2  <= w_in2_nxt;
            r_en   <= w_en_nxt;
        end
    end

    assign o_ctrl    = r_ctrl;
    assign o_period  = r_period_sh;
    assign o_duty    = r_duty_sh;
    assign o_dead    = r_dead;
    assign o_dead_st = (r_state == ST_DEAD);
    assign o_in1     = r_in1;
    assign o_in2     = r_in2;
    assign o_en      = r_en;

endmodule
`default_nettype wire

// File: rtl/l298n_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : l298n_pwm_multi
// Description : NUM_CH-channel L298N H-bridge PWM controller with an
//               Avalon-MM slave. Holds the address decode and the readback
//               mux; each channel is an l298n_pwm_channel instance.
// Ports       : clk, reset_n (async, active-low)
//               avs_address/avs_write/avs_read/avs_writedata/avs_readdata
//                 - channel c at words 4c+0..3 (CTRL, PERIOD, DUTY, DEAD),
//                   read-only STATUS at word 4*NUM_CH (bit c = DEAD)
//               pwm_in1/pwm_in2/pwm_en - per-channel bridge pins
// Revision    : 1.0 - initial release
// ============================================================================
module l298n_pwm_multi
    import l298n_pwm_pkg::*;
#(
    parameter  int NUM_CH = 2,
    parameter  int CNT_W  = 16,
    parameter  int DEAD_W = 8,
    localparam int ADDR_W = $clog2(4 * NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] pwm_in1,
    output logic [NUM_CH-1:0] pwm_in2,
    output logic [NUM_CH-1:0] pwm_en
);

    localparam logic [ADDR_W-1:0] c_status_addr = ADDR_W'(c_regs_per_ch * NUM_CH);

    logic [c_ctrl_w-1:0] w_rb_ctrl   [NUM_CH];
    logic [CNT_W-1:0]    w_rb_period [NUM_CH];
    logic [CNT_W-1:0]    w_rb_duty   [NUM_CH];
    logic [DEAD_W-1:0]   w_rb_dead   [NUM_CH];
    logic [NUM_CH-1:0]   w_status;
    logic [31:0]         w_rdata;
    logic [31:0]         r_readdata;
    logic                w_unused_wdata;

    // Only the low bits of the write bus reach the channels.
    assign w_unused_wdata = ^avs_writedata;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic w_wr_ctrl;
            logic w_wr_period;
            logic w_wr_duty;
            logic w_wr_dead;

            assign w_wr_ctrl   = avs_write && (avs_address == ADDR_W'(c_regs_per_ch * g + c_ofs_ctrl));
            assign w_wr_period = avs_write && (avs_address == ADDR_W'(c_regs_per_ch * g + c_ofs_period));
            assign w_wr_duty   = avs_write && (avs_address == ADDR_W'(c_regs_per_ch * g + c_ofs_duty));
            assign w_wr_dead   = avs_write && (avs_address == ADDR_W'(c_regs_per_ch * g + c_ofs_dead));

            l298n_pwm_channel #(
                .CNT_W  (CNT_W),
                .DEAD_W (DEAD_W)
            ) u_ch (
                .clk          (clk),
                .rst_n        (reset_n),
                .i_wr_ctrl    (w_wr_ctrl),
                .i_wr_period  (w_wr_period),
                .i_wr_duty    (w_wr_duty),
                .i_wr_dead    (w_wr_dead),
                .i_wdata_ctrl (avs_writedata[c_ctrl_w-1:0]),
                .i_wdata_cnt  (avs_writedata[CNT_W-1:0]),
                .i_wdata_dead (avs_writedata[DEAD_W-1:0]),
                .o_ctrl       (w_rb_ctrl[g]),
                .o_period     (w_rb_period[g]),
                .o_duty       (w_rb_duty[g]),
                .o_dead       (w_rb_dead[g]),
                .o_dead_st    (w_status[g]),
                .o_in1        (pwm_in1[g]),
                .o_in2        (pwm_in2[g]),
                .o_en         (pwm_en[g])
            );
        end
    endgenerate

    // Readback mux; anything not matched (unmapped words) reads as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (avs_address == ADDR_W'(c_regs_per_ch * i + c_ofs_ctrl)) begin
                w_rdata = 32'(w_rb_ctrl[i]);
            end
            if (avs_address == ADDR_W'(c_regs_per_ch * i + c_ofs_period)) begin
                w_rdata = 32'(w_rb_period[i]);
            end
            if (avs_address == ADDR_W'(c_regs_per_ch * i + c_ofs_duty)) begin
                w_rdata = 32'(w_rb_duty[i]);
            end
            if (avs_address == ADDR_W'(c_regs_per_ch * i + c_ofs_dead)) begin
                w_rdata = 32'(w_rb_dead[i]);
            end
        end
        if (avs_address == c_status_addr) begin
            w_rdata = 32'(w_status);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_l298n_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_l298n_pwm_multi
// Description : Self-checking bench for l298n_pwm_multi. Register contents
//               are tracked in a small array model; PWM behaviour is judged
//               from duty/period arithmetic, dead-time lengths and pin
//               levels observed over whole windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l298n_pwm_multi;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 16;
    localparam int DEAD_W      = 8;
    localparam int ADDR_W      = $clog2(4 * NUM_CH + 1);
    localparam int STATUS_ADDR = 4 * NUM_CH;
    localparam int N_ADDR      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] avs_address = '0;
    logic              avs_write = 1'b0;
    logic              avs_read = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] pwm_in1;
    logic [NUM_CH-1:0] pwm_in2;
    logic [NUM_CH-1:0] pwm_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_reg [4*NUM_CH];

    always #5 clk = ~clk;

    l298n_pwm_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DEAD_W (DEAD_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_read      (avs_read),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .pwm_in1       (pwm_in1),
        .pwm_in2       (pwm_in2),
        .pwm_en        (pwm_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_mask(input int a);
        case (a % 4)
            0:       return 32'h0000_0007;
            1, 2:    return 32'h0000_FFFF;
            default: return 32'h0000_00FF;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input int a);
        if (a < 4 * NUM_CH) return m_reg[a];
        return 32'h0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4 * NUM_CH; i++) m_reg[i] = '0;
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = ADDR_W'(a);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        if (a < 4 * NUM_CH) m_reg[a] = d & reg_mask(a);
    endtask

    task automatic bus_read(input int a, output logic [31:0] d);
        @(negedge clk);
        avs_address = ADDR_W'(a);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic read_all(input string tag);
        logic [31:0] d;
        for (int a = 0; a < N_ADDR; a++) begin
            bus_read(a, d);
            chk($sformatf("%s_rd%0d", tag, a), d, exp_read(a));
        end
    endtask

    // Idle the channel, load PERIOD/DUTY while idle, then start it.
    task automatic cfg(input int c, input int per, input int duty, input int dir);
        bus_write(4 * c, 32'h0);
        repeat (20) @(negedge clk);
        bus_write(4 * c + 1, 32'(per));
        bus_write(4 * c + 2, 32'(duty));
        bus_write(4 * c, 32'(1 | (dir << 1)));
    endtask

    // Both channels run random configurations together; over a window
    // that is a whole number of periods of each, EN must be high exactly
    // min(duty, period) cycles per period and IN1/IN2 must follow dir.
    task automatic pwm_random_test(input int iters);
        int p [NUM_CH];
        int d [NUM_CH];
        int dr[NUM_CH];
        int hi[NUM_CH];
        int de[NUM_CH];
        int w;
        for (int it = 0; it < iters; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                p[c]  = int'($urandom_range(1, 12));
                d[c]  = int'($urandom_range(0, 32'(p[c] + 2)));
                dr[c] = int'($urandom_range(0, 1));
                hi[c] = 0;
                de[c] = 0;
                cfg(c, p[c], d[c], dr[c]);
            end
            repeat (4) @(negedge clk);
            w = 2 * p[0] * p[1];
            for (int k = 0; k < w; k++) begin
                @(negedge clk);
                for (int c = 0; c < NUM_CH; c++) begin
                    if (pwm_en[c]) hi[c]++;
                    if (pwm_in1[c] !== dr[c][0] || pwm_in2[c] !== !dr[c][0]) de[c]++;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                chk($sformatf("pwm_hi_it%0d_ch%0d_p%0d_d%0d", it, c, p[c], d[c]),
                    32'(hi[c]), 32'((w / p[c]) * ((d[c] < p[c]) ? d[c] : p[c])));
                chk($sformatf("pwm_dir_it%0d_ch%0d", it, c), 32'(de[c]), 32'h0);
            end
        end
    endtask

    // Direction reversal on channel c with both channels at 100% duty:
    // every low EN cycle on c is dead time.
    task automatic dead_test(input int c, input int dead);
        int lows, st_hi, other_lows, held_err;
        int o;
        o = 1 - c;
        lows = 0; st_hi = 0; other_lows = 0; held_err = 0;
        cfg(0, 8, 8, 0);
        cfg(1, 8, 8, 0);
        bus_write(4 * c + 3, 32'(dead));
        bus_write(4 * c, 32'h3);
        avs_address = ADDR_W'(STATUS_ADDR);
        avs_read    = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!pwm_en[c]) begin
                lows++;
                if (pwm_in1[c] !== 1'b0 || pwm_in2[c] !== 1'b1) held_err++;
            end
            if (avs_readdata[c]) st_hi++;
            if (!pwm_en[o]) other_lows++;
        end
        avs_read = 1'b0;
        chk($sformatf("dead_len_ch%0d_d%0d", c, dead), 32'(lows), 32'(dead + 1));
        chk($sformatf("dead_status_ch%0d_d%0d", c, dead), 32'(st_hi), 32'(dead + 1));
        chk($sformatf("dead_hold_ch%0d", c), 32'(held_err), 32'h0);
        chk($sformatf("dead_other_ch%0d", o), 32'(other_lows), 32'h0);
        chk($sformatf("dead_newdir_ch%0d", c),
            {29'h0, pwm_en[c], pwm_in1[c], pwm_in2[c]}, 32'b110);
    endtask

    int          rec [20];
    int          lows_b;
    int          brk_err;
    int          found;
    logic [31:0] rd;

    initial begin
        model_clear();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        chk("rst_pins", {26'h0, pwm_in1, pwm_in2, pwm_en}, 32'h0);
        reset_n = 1'b1;
        chk("rst_readdata", avs_readdata, 32'h0);
        read_all("rst");

        // ---------------- register readback ----------------
        for (int a = 0; a < N_ADDR; a++) begin
            logic [31:0] v;
            v = $urandom;
            if (a < 4 * NUM_CH && (a % 4) == 0) v = v & 32'hFFFF_FFFE;
            bus_write(a, v);
        end
        read_all("regs");

        // ---------------- PWM duty/period, both channels ----------------
        pwm_random_test(6);

        // ---------------- PERIOD = 0 keeps EN low ----------------
        cfg(0, 0, 5, 1);
        found = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k >= 4 && (pwm_en[0] || pwm_in1[0] !== 1'b1 || pwm_in2[0] !== 1'b0)) found++;
        end
        chk("period0_en_low", 32'(found), 32'h0);

        // ---------------- DUTY > PERIOD gives 100% ----------------
        cfg(0, 10, 12, 0);
        found = 0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!pwm_en[0]) found++;
        end
        chk("duty_over_period_lows", 32'(found), 32'h0);

        // ---------------- shadowed DUTY update ----------------
        cfg(0, 10, 3, 0);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (pwm_en[0]) begin
                @(negedge clk);
                if (!pwm_en[0]) found = 1;
            end
        end
        chk("shadow_sync_found", 32'(found), 32'h1);
        // Now aligned just after a high burst; wait for next rising edge.
        found = 0;
        for (int k = 0; k < 20 && found == 0; k++) begin
            @(negedge clk);
            if (pwm_en[0]) found = 1;
        end
        chk("shadow_edge_found", 32'(found), 32'h1);
        rec[0] = int'(pwm_en[0]);
        fork
            begin
                for (int k = 1; k < 20; k++) begin
                    @(negedge clk);
                    rec[k] = int'(pwm_en[0]);
                end
            end
            begin
                repeat (2) @(negedge clk);
                bus_write(2, 32'd7);
            end
        join
        begin
            int h1, h2;
            h1 = 0; h2 = 0;
            for (int k = 0; k < 10; k++) h1 += rec[k];
            for (int k = 10; k < 20; k++) h2 += rec[k];
            chk("shadow_cur_period_hi", 32'(h1), 32'd3);
            chk("shadow_next_period_hi", 32'(h2), 32'd7);
        end

        // ---------------- dead time on direction change ----------------
        dead_test(0, 5);
        dead_test(1, 0);
        dead_test(int'($urandom_range(0, 1)), int'($urandom_range(1, 10)));

        // ---------------- brake via DEAD, CTRL rewritten mid-dead ----------------
        cfg(0, 8, 8, 0);
        cfg(1, 8, 8, 0);
        bus_write(3, 32'd6);
        lows_b = 0;
        brk_err = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (!pwm_en[0]) lows_b++;
                    if (k >= 30 && (pwm_en[0] !== 1'b1 || pwm_in1[0] !== 1'b0 || pwm_in2[0] !== 1'b0))
                        brk_err++;
                end
            end
            begin
                bus_write(0, 32'h3);
                repeat (2) @(negedge clk);
                bus_write(0, 32'h5);
            end
        join
        chk("brake_dead_len", 32'(lows_b), 32'd7);
        chk("brake_steady", 32'(brk_err), 32'h0);

        // ---------------- async reset during DEAD on ch1 ----------------
        cfg(0, 8, 8, 0);
        cfg(1, 8, 8, 0);
        bus_write(7, 32'd200);
        bus_write(4, 32'h3);
        repeat (5) @(negedge clk);
        chk("pre_rst_en", 32'(pwm_en), 32'b01);
        chk("pre_rst_in2", 32'(pwm_in2), 32'b11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_pins", {26'h0, pwm_in1, pwm_in2, pwm_en}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        chk("post_rst_readdata", avs_readdata, 32'h0);
        repeat (5) @(negedge clk);
        chk("post_rst_pins", {26'h0, pwm_in1, pwm_in2, pwm_en}, 32'h0);
        read_all("post_rst");
        bus_read(STATUS_ADDR, rd);
        chk("post_rst_status", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
